// File: rtl/compressor_result_serializer_pkg.sv
// Shared types and helpers for the compressor result serializer.
package compressor_result_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int SETTLE_W = 4;

  // ceil(log2(n)), never narrower than one bit so a 1-bit frame still has a counter
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/compressor_result_serializer_piso.sv
// Parallel-in serial-out register: LSB first, registered data/valid/last.
module compressor_result_serializer_piso
  import compressor_result_serializer_pkg::*;
#(
  parameter int TOTAL_W = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [TOTAL_W-1:0] din,
  output logic               ser_data,
  output logic               ser_valid,
  output logic               ser_last
);

  localparam int CNT_W = cnt_width(TOTAL_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_W - 1);

  logic [TOTAL_W-1:0] shadow;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nxt;

  assign bit_cnt_nxt = bit_cnt + CNT_W'(1);

  // shadow shifts right so the outgoing bit always sits in a flop; it drains to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      bit_cnt   <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else if (load) begin
      shadow    <= din;
      bit_cnt   <= '0;
      ser_valid <= 1'b1;
      ser_last  <= (TOTAL_W == 1);
    end else if (advance && ser_valid) begin
      shadow <= shadow >> 1;
      if (ser_last) begin
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
      end else begin
        bit_cnt  <= bit_cnt_nxt;
        ser_last <= (bit_cnt_nxt == LAST_IDX);
      end
    end
  end

  assign ser_data = shadow[0];

endmodule

// File: rtl/compressor_result_serializer.sv
// Captures the compressor dst columns after a settle delay and streams them out serially.
module compressor_result_serializer
  import compressor_result_serializer_pkg::*;
#(
  parameter int N_DST  = 26,
  parameter int DST_W  = 1,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DST*DST_W-1:0]   dst,
  input  logic                     start,
  output logic                     busy,
  output logic                     ser_data,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic                     ser_last,
  output logic                     done
);

  localparam int TOTAL_W = N_DST * DST_W;

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_WAIT    = 3'(ST_WAIT);
  localparam logic [2:0] S_CAPTURE = 3'(ST_CAPTURE);
  localparam logic [2:0] S_SHIFT   = 3'(ST_SHIFT);
  localparam logic [2:0] S_DONE    = 3'(ST_DONE);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                handshake;
  logic                load;

  assign handshake = ser_valid && ser_ready;
  assign load      = (state == S_CAPTURE);

  // WAIT leaves when the count would reach zero, so it lasts exactly SETTLE cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (SETTLE == 0) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (settle_cnt <= SETTLE_W'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SHIFT;
      S_SHIFT:   if (handshake && ser_last) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        settle_cnt <= SETTLE_LD;
      end else if (state == S_WAIT && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SETTLE_W'(1);
      end
      busy <= (state_nxt == S_WAIT) || (state_nxt == S_CAPTURE) || (state_nxt == S_SHIFT);
      done <= (state_nxt == S_DONE);
    end
  end

  compressor_result_serializer_piso #(
    .TOTAL_W (TOTAL_W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (handshake),
    .din       (dst),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_last  (ser_last)
  );

endmodule

// File: tb/tb_compressor_result_serializer.sv
// Bench for compressor_result_serializer: default 26x1/settle-2 instance and an 4x2/settle-0 instance.
module tb_compressor_result_serializer;

  localparam int A_TW = 26;
  localparam int B_TW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [A_TW-1:0] dst_a;
  logic start_a, ready_a, busy_a, data_a, valid_a, last_a, done_a;
  logic [B_TW-1:0] dst_b;
  logic start_b, ready_b, busy_b, data_b, valid_b, last_b, done_b;

  compressor_result_serializer u_dut_a (
    .clk(clk), .rst(rst), .dst(dst_a), .start(start_a), .busy(busy_a),
    .ser_data(data_a), .ser_valid(valid_a), .ser_ready(ready_a),
    .ser_last(last_a), .done(done_a)
  );

  compressor_result_serializer #(.N_DST(4), .DST_W(2), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst(rst), .dst(dst_b), .start(start_b), .busy(busy_b),
    .ser_data(data_b), .ser_valid(valid_b), .ser_ready(ready_b),
    .ser_last(last_b), .done(done_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int sel, output logic v, output logic d, output logic l,
                        output logic b, output logic dn);
    if (sel == 0) begin
      v = valid_a; d = data_a; l = last_a; b = busy_a; dn = done_a;
    end else begin
      v = valid_b; d = data_b; l = last_b; b = busy_b; dn = done_b;
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic rdy);
    if (sel == 0) begin
      start_a = st; ready_a = rdy;
    end else begin
      start_b = st; ready_b = rdy;
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    logic r;
    r = 1'b1;
    if (mode == 1) r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else if (mode == 2) r = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Reference: the frame is dst read LSB first; first bit at start+settle+2, done one
  // cycle after the final handshake, valid continuous and stable while stalled.
  task automatic run_frame(input int sel, input logic [31:0] d, input int exp_lat,
                           input int rmode, input bit swap, input bit restart,
                           input string tag);
    int  tw, cyc, hs, first, last_hs, dones, extra;
    bit  q[$];
    logic v, dt, l, b, dn, pv, pd, pl, prdy, rdy, st;
    tw = (sel == 0) ? A_TW : B_TW;
    for (int i = 0; i < tw; i++) q.push_back(d[i]);
    hs = 0; first = -1; last_hs = -1; dones = 0;
    pv = 1'b0; pd = 1'b0; pl = 1'b0; prdy = 1'b0;
    if (sel == 0) dst_a = d[A_TW-1:0];
    else dst_b = d[B_TW-1:0];
    drive(sel, 1'b1, 1'b0);
    step();
    cyc = 1;
    sample(sel, v, dt, l, b, dn);
    check({tag, " busy after start"}, 32'(b), 32'd1);
    while (cyc < 400) begin
      sample(sel, v, dt, l, b, dn);
      if (dn) begin
        dones++;
        break;
      end
      if (pv && !prdy) begin
        check({tag, " valid held in stall"}, 32'(v), 32'd1);
        check({tag, " data held in stall"}, 32'(dt), 32'(pd));
        check({tag, " last held in stall"}, 32'(l), 32'(pl));
      end
      if (v) begin
        if (first < 0) begin
          first = cyc;
          check({tag, " first-bit latency"}, 32'(cyc), 32'(exp_lat));
        end
        if (hs < tw) begin
          check({tag, $sformatf(" bit %0d", hs)}, 32'(dt), 32'(q[hs]));
          check({tag, $sformatf(" last at bit %0d", hs)}, 32'(l), 32'(hs == tw - 1));
        end else begin
          check({tag, " valid beyond frame"}, 32'(hs), 32'(tw - 1));
        end
      end else if (first >= 0) begin
        check({tag, " valid gap mid-frame"}, 32'(hs), 32'(tw));
      end else begin
        check({tag, " busy before first bit"}, 32'(b), 32'd1);
      end
      rdy = ready_pat(rmode, cyc);
      if (swap && cyc == exp_lat + 1) begin
        if (sel == 0) dst_a = '1;
        else dst_b = '1;
      end
      st = restart && (cyc == exp_lat + 6);
      drive(sel, st, rdy);
      pv = v; pd = dt; pl = l; prdy = rdy;
      if (v && rdy) begin
        hs++;
        last_hs = cyc;
      end
      step();
      cyc++;
    end
    check({tag, " done seen"}, 32'(dones), 32'd1);
    check({tag, " handshake count"}, 32'(hs), 32'(tw));
    check({tag, " done after last handshake"}, 32'(cyc), 32'(last_hs + 1));
    if (rmode == 0) check({tag, " done latency"}, 32'(cyc - first), 32'(tw));
    check({tag, " busy low in done"}, 32'(b), 32'd0);
    check({tag, " valid low in done"}, 32'(v), 32'd0);
    drive(sel, restart, 1'b1);
    step();
    drive(sel, 1'b0, 1'b1);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      sample(sel, v, dt, l, b, dn);
      if (v || dn || b) extra++;
      step();
    end
    check({tag, " quiet after frame"}, 32'(extra), 32'd0);
  endtask

  task automatic abort_test();
    logic v, dt, l, b, dn;
    int hs, cyc, extra;
    bit hit;
    hs = 0; cyc = 0; hit = 0;
    dst_a = 26'h155AA33;
    drive(0, 1'b1, 1'b1);
    step();
    drive(0, 1'b0, 1'b1);
    while (cyc < 100 && !hit) begin
      sample(0, v, dt, l, b, dn);
      if (v && hs == 10) begin
        hit = 1;
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        if (v) hs++;
        step();
        cyc++;
      end
    end
    check("abort reached bit 10", 32'(hit), 32'd1);
    sample(0, v, dt, l, b, dn);
    check("abort valid", 32'(v), 32'd0);
    check("abort busy", 32'(b), 32'd0);
    check("abort done", 32'(dn), 32'd0);
    check("abort data/last", {30'd0, dt, l}, 32'd0);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      sample(0, v, dt, l, b, dn);
      if (v || dn || b) extra++;
    end
    check("abort no frame/done", 32'(extra), 32'd0);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] d;
    int          rmode;
    bit          swap;
    bit          restart;
    int          exp_lat;
    string       tag;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic v, dt, l, b, dn;
    vecs[0] = '{0, 32'h2AAAAAA, 0, 0, 0, 4, "alt"};
    vecs[1] = '{0, 32'h0000001, 1, 0, 0, 4, "stall"};
    vecs[2] = '{0, 32'h0000000, 0, 1, 0, 4, "dst-swap"};
    vecs[3] = '{0, 32'h1234567, 0, 0, 1, 4, "restart"};
    vecs[4] = '{1, 32'h00000B4, 0, 0, 0, 2, "b-B4"};
    vecs[5] = '{1, 32'h000005A, 1, 1, 1, 2, "b-stall"};

    rst = 1'b1;
    dst_a = '0; dst_b = '0;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    repeat (3) step();
    sample(0, v, dt, l, b, dn);
    check("reset a outputs", {27'd0, v, dt, l, b, dn}, 32'd0);
    sample(1, v, dt, l, b, dn);
    check("reset b outputs", {27'd0, v, dt, l, b, dn}, 32'd0);
    rst = 1'b0;
    step();
    sample(0, v, dt, l, b, dn);
    check("post-reset a outputs", {27'd0, v, dt, l, b, dn}, 32'd0);
    sample(1, v, dt, l, b, dn);
    check("post-reset b outputs", {27'd0, v, dt, l, b, dn}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].sel, vecs[i].d, vecs[i].exp_lat, vecs[i].rmode,
                vecs[i].swap, vecs[i].restart, vecs[i].tag);

    abort_test();
    run_frame(0, 32'h3C0FF01, 4, 0, 0, 0, "after-abort");

    for (int i = 0; i < 8; i++) begin
      int sel;
      sel = i % 2;
      run_frame(sel, $urandom, (sel == 0) ? 4 : 2, 2, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compressor_result_serializer.md
Name: compressor_result_serializer

Overview:
- Output-side counterpart of the serial-input shift-register harness around the compressor.
- Captures the compressor's parallel dst column outputs into a shadow register after a programmable settle delay.
- Streams the captured bits out on one serial pin with a valid/ready handshake, so a wide result needs no wide top-level IO.
- Sits between the compressor dst ports and the top-level pins.

Parameters:
- N_DST, 26, number of dst columns captured.
- DST_W, 1, bit width of each dst column (all columns equal).
- SETTLE, 2, cycles waited after start before capture (0..15); covers compressor pipelining/settling.
- TOTAL_W, N_DST*DST_W (derived, not overridable), serial frame length in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- dst  in  TOTAL_W  packed compressor outputs; dst0 occupies bits [DST_W-1:0], dstK occupies bits [K*DST_W +: DST_W].
- start  in  1  one-cycle request to capture and send a frame.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last bit's handshake.
- ser_data  out  1  current serial bit.
- ser_valid  out  1  ser_data is valid.
- ser_ready  in  1  sink accepts the bit when ser_valid && ser_ready.
- ser_last  out  1  high with the final bit of a frame.
- done  out  1  one-cycle pulse after the final bit's handshake.

Behaviour:
- Reset is synchronous and active-high; the polarity and synchronicity are fixed. Clock port is clk, reset port is rst.
- Outputs while rst=1 and on the cycle after it deasserts: busy=0, ser_valid=0, ser_data=0, ser_last=0, done=0. Shadow register and counters clear to 0.
- States:
  - IDLE: start=1 -> WAIT, load the settle counter with SETTLE. If SETTLE=0, go directly to CAPTURE.
  - WAIT: decrement the counter each cycle; at 0 -> CAPTURE.
  - CAPTURE: shadow <= dst; bit counter <= 0; -> SHIFT.
  - SHIFT:
    - ser_valid=1; ser_data=shadow[bit counter]; bits are sent LSB first, so dst0 bit0 goes first.
    - ser_last=1 when bit counter == TOTAL_W-1.
    - On handshake, advance the counter. On the last handshake -> DONE.
    - While ser_ready=0: ser_data, ser_valid and ser_last hold stable and the counter does not advance.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in WAIT, CAPTURE and SHIFT.
- Latency: with SETTLE=S and ser_ready held at 1:
  - first bit valid S+2 cycles after the start cycle (S = settle cycles; +1 for the capture state; +1 for SHIFT entry).
  - done appears TOTAL_W cycles after the first bit.
- start while busy or in DONE is ignored; there is no queueing.
- dst changes after CAPTURE do not affect the frame in flight.
- Bit counter width is clog2(TOTAL_W). There is no wrap-around: the counter is reloaded only in CAPTURE.
- rst asserted mid-frame aborts immediately to IDLE: no done pulse, ser_valid=0 the next cycle.
- All outputs are registered, with no combinational path from ser_ready to ser_valid.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, WAIT, CAPTURE, SHIFT, DONE), 3-bit encoding;
  - the SETTLE width constant (4);
  - a clog2-based function for counter widths.
- One natural sub-module: serializer_piso, a TOTAL_W-bit parallel-in serial-out register with load, advance and last-flag.
- The FSM and settle counter stay in the top module.

Test Plan:
- Default params, ser_ready=1, dst=26'h2AAAAAA, start pulse:
  - first ser_valid arrives 4 cycles after start.
  - bits arrive 0,1,0,1,... for 26 cycles.
  - ser_last appears on the 26th bit, done one cycle later, busy then 0.
- ser_ready toggled 1,0,0,1 repeating, with dst=26'h0000001:
  - bit 1 is presented first and held stable across stalls.
  - exactly 26 handshakes occur, and done follows the 26th.
- dst changed to 26'h3FFFFFF two cycles after CAPTURE, for a frame started with 26'h0:
  - all 26 serialized bits are 0.
- start pulsed again mid-frame and on the DONE cycle:
  - both are ignored; one frame only, single done.
- rst asserted for 1 cycle at bit 10:
  - ser_valid=0 and busy=0 next cycle, no done.
  - a new start afterwards sends a full 26-bit frame from bit 0.
- SETTLE=0, DST_W=2, N_DST=4, dst=8'hB4, ready=1:
  - first bit arrives 2 cycles after start.
  - the stream is 0,0,1,0,1,1,0,1.
